// File: rtl/sarlock_key_loader.sv
// sarlock_key_loader: serial (LSB-first) key loader for SARLock-locked c432.
// Bits stream into a shadow register over valid/ready. A commit pulse
// transfers the shadow atomically to key_out, so the locked netlist never
// sees a partially loaded key.
// Optional feature: define KEY_PARITY_EN to append one even-parity bit
// (index KEY_W). The key is then checked for parity at commit time.
module sarlock_key_loader #(
  parameter int KEY_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic             sin_ready,
  input  logic             commit,
  input  logic             clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic [CNT_W-1:0] bits_rcvd
);

`ifdef KEY_PARITY_EN
  localparam int LEN = KEY_W + 1;
`else
  localparam int LEN = KEY_W;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t           state, state_nxt;
  logic [LEN-1:0]   shadow;
  logic             accept;
  logic             last_bit;
  logic             key_good;

  // clear and commit both outrank a bit offered in the same cycle.
  assign accept   = sin_valid & sin_ready & ~commit & ~clear;
  assign last_bit = (bits_rcvd == CNT_W'(LEN - 1));

`ifdef KEY_PARITY_EN
  // Even parity over key plus parity bit.
  assign key_good = (state == FULL) & ~(^shadow);
`else
  assign key_good = (state == FULL);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: any commit or clear returns to IDLE; the LEN-th bit fills.
  always_comb begin
    state_nxt = state;
    if (clear || commit)
      state_nxt = IDLE;
    else if (accept)
      state_nxt = last_bit ? FULL : SHIFT;
  end

  // Output decode from registered state only.
  always_comb begin
    sin_ready = (state != FULL);
  end

  // Datapath: shadow fill, atomic key transfer, sticky error, bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      bits_rcvd <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else if (clear) begin
      shadow    <= '0;
      bits_rcvd <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else if (commit) begin
      shadow    <= '0;
      bits_rcvd <= '0;
      if (key_good) begin
        key_out   <= shadow[KEY_W-1:0];
        key_valid <= 1'b1;
        load_err  <= 1'b0;
      end else begin
        load_err  <= 1'b1;
      end
    end else if (accept) begin
      // Shadow is zero above the fill point, so OR-ing in the bit is a write.
      shadow    <= shadow | ({{(LEN-1){1'b0}}, sin_bit} << bits_rcvd);
      bits_rcvd <= bits_rcvd + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sarlock_key_loader.sv
// tb_sarlock_key_loader: scoreboard bench for sarlock_key_loader.
// Expected {key_out,key_valid,load_err,bits_rcvd,sin_ready} vectors are
// queued when a commit/clear/reset is driven and popped after the edge.
module tb_sarlock_key_loader;

`ifdef KEY_PARITY_EN
  localparam int LEN = 9;
`else
  localparam int LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin_valid = 1'b0;
  logic       sin_bit = 1'b0;
  logic       sin_ready;
  logic       commit = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] key_out;
  logic       key_valid;
  logic       load_err;
  logic [3:0] bits_rcvd;

  logic [14:0] obs;
  logic [14:0] exp_v;
  logic [14:0] sbq[$];
  int n_tests = 0;
  int n_fail  = 0;

  sarlock_key_loader #(.KEY_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_bit(sin_bit),
    .sin_ready(sin_ready), .commit(commit), .clear(clear),
    .key_out(key_out), .key_valid(key_valid), .load_err(load_err),
    .bits_rcvd(bits_rcvd)
  );

  always #5 clk = ~clk;

  assign obs = {key_out, key_valid, load_err, bits_rcvd, sin_ready};

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Stream bits lo..hi-1 of v, one per cycle.
  task automatic send(input logic [8:0] v, input int lo, input int hi);
    logic [8:0] t;
    for (int i = lo; i < hi; i++) begin
      t = v >> i;
      sin_valid = 1'b1;
      sin_bit   = t[0];
      step();
    end
    sin_valid = 1'b0;
    sin_bit   = 1'b0;
  endtask

  // Key framed with its even-parity bit (ignored when parity is off).
  function automatic logic [8:0] frame(input logic [7:0] k);
    return {^k, k};
  endfunction

  task automatic test_reset();
    rst = 1'b1; sin_valid = 1'b1; sin_bit = 1'b1;
    sbq.push_back({8'h00, 1'b0, 1'b0, 4'd0, 1'b1});
    step(); step();
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL reset_held: got %h exp %h (key|kv|err|cnt|rdy)", obs, exp_v); end
    rst = 1'b0; sin_valid = 1'b0; sin_bit = 1'b0;
    sbq.push_back({8'h00, 1'b0, 1'b0, 4'd0, 1'b1});
    step();
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL reset_release: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_load_commit();
    logic [8:0] f;
    f = frame(8'h4D);
    send(f, 0, 4);
    n_tests++;
    if (key_out !== 8'h00 || bits_rcvd !== 4'd4 || sin_ready !== 1'b1) begin n_fail++;
      $display("FAIL partial_load: got key=%h cnt=%0d rdy=%b exp key=00 cnt=4 rdy=1",
               key_out, bits_rcvd, sin_ready); end
    send(f, 4, LEN);
    n_tests++;
    if (key_out !== 8'h00 || bits_rcvd !== 4'(LEN) || sin_ready !== 1'b0) begin n_fail++;
      $display("FAIL full_load: got key=%h cnt=%0d rdy=%b exp key=00 cnt=%0d rdy=0",
               key_out, bits_rcvd, sin_ready, LEN); end
    sbq.push_back({8'h4D, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL commit_4d: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_incomplete();
    send(frame(8'hFF), 0, 5);
    n_tests++;
    if (bits_rcvd !== 4'd5) begin n_fail++;
      $display("FAIL five_bits: got cnt=%0d exp 5", bits_rcvd); end
    sbq.push_back({8'h4D, 1'b1, 1'b1, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL incomplete_commit: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_full_hold();
    logic [8:0] f;
    f = frame(8'hA5);
    send(f, 0, LEN - 1);
    n_tests++;
    if (sin_ready !== 1'b1) begin n_fail++;
      $display("FAIL ready_before_last: got %b exp 1", sin_ready); end
    send(f, LEN - 1, LEN);
    for (int i = 0; i < 3; i++) begin
      sin_valid = 1'b1; sin_bit = 1'b1;
      step();
      n_tests++;
      if (sin_ready !== 1'b0 || bits_rcvd !== 4'(LEN)) begin n_fail++;
        $display("FAIL full_hold_%0d: got rdy=%b cnt=%0d exp rdy=0 cnt=%0d",
                 i, sin_ready, bits_rcvd, LEN); end
    end
    sin_valid = 1'b0; sin_bit = 1'b0;
    sbq.push_back({8'hA5, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL commit_a5: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_commit_with_accept();
    logic [8:0] f;
    logic [8:0] t;
    f = frame(8'h3C);
    send(f, 0, LEN - 1);
    t = f >> (LEN - 1);
    sbq.push_back({8'hA5, 1'b1, 1'b1, 4'd0, 1'b1});
    commit = 1'b1; sin_valid = 1'b1; sin_bit = t[0];
    step();
    commit = 1'b0; sin_valid = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL commit_plus_last_bit: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_clear_commit();
    send(frame(8'h99), 0, LEN);
    sbq.push_back({8'h00, 1'b0, 1'b0, 4'd0, 1'b1});
    clear = 1'b1; commit = 1'b1; step(); clear = 1'b0; commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL clear_over_commit: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_reset_midload();
    send(frame(8'h3C), 0, LEN);
    sbq.push_back({8'h3C, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL commit_3c: got %h exp %h", obs, exp_v); end
    send(frame(8'hFF), 0, 4);
    // Assert reset between edges: outputs must drop without a clock.
    #2 rst = 1'b1;
    sbq.push_back({8'h00, 1'b0, 1'b0, 4'd0, 1'b1});
    #1;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL async_reset: got %h exp %h", obs, exp_v); end
    step(); rst = 1'b0;
    send(frame(8'hFF), 0, LEN);
    sbq.push_back({8'hFF, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL reload_ff: got %h exp %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    send(frame(8'h12), 0, LEN);
    sbq.push_back({8'h12, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL b2b_first: got %h exp %h", obs, exp_v); end
    send(frame(8'h34), 0, LEN);
    sbq.push_back({8'h34, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL b2b_second: got %h exp %h", obs, exp_v); end
  endtask

`ifdef KEY_PARITY_EN
  task automatic test_parity();
    send({1'b1, 8'h4D}, 0, LEN);
    sbq.push_back({8'h34, 1'b1, 1'b1, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL parity_bad: got %h exp %h", obs, exp_v); end
    send({1'b0, 8'h4D}, 0, LEN);
    sbq.push_back({8'h4D, 1'b1, 1'b0, 4'd0, 1'b1});
    commit = 1'b1; step(); commit = 1'b0;
    exp_v = sbq.pop_front(); n_tests++;
    if (obs !== exp_v) begin n_fail++;
      $display("FAIL parity_good: got %h exp %h", obs, exp_v); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_commit();
    test_incomplete();
    test_full_hold();
    test_commit_with_accept();
    test_clear_commit();
    test_reset_midload();
    test_back_to_back();
`ifdef KEY_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
